imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, instruction word width in bits; only 32 is supported.
REQ-002 Parameter ADDR_WIDTH, default 10, word-address width of the instruction memory.
REQ-003 Parameter DEPTH, default 1024, maximum number of loadable words.
REQ-004 i_sys_clk  input  1  system clock; all logic on rising edge.
REQ-005 i_sys_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_load_start  input  1  single-cycle pulse that begins a load.
REQ-007 i_byte_valid  input  1  byte-stream valid.
REQ-008 i_byte_data  input  8  byte-stream payload.
REQ-009 o_byte_ready  output  1  byte-stream ready; a byte transfers when valid and ready are both high on a clock edge.
REQ-010 o_mem_wr_en  output  1  instruction-memory write strobe.
REQ-011 o_mem_wr_addr  output  ADDR_WIDTH  word write address.
REQ-012 o_mem_wr_data  output  DATA_WIDTH  write data.
REQ-013 o_cpu_rst_n  output  1  core reset, active low.
REQ-014 o_done  output  1  load completed successfully.
REQ-015 o_err  output  1  load aborted.

Function
REQ-016 States SHALL be IDLE, LEN, DATA, WRITE, CKSUM (macro only), DONE and ERR.
REQ-017 Stream format SHALL be a 32-bit word count N, then N 32-bit words; every word is sent little-endian, least-significant byte first.
REQ-018 IDLE -> LEN on i_load_start; in DONE or ERR, i_load_start SHALL restart the load by going to LEN and clearing the counters.
REQ-019 i_load_start SHALL be ignored in LEN, DATA, WRITE and CKSUM.
REQ-020 o_byte_ready SHALL be 1 only in LEN, DATA and CKSUM; a byte is never accepted in any other state.
REQ-021 A 2-bit byte counter SHALL place each accepted byte at bits [8k+7:8k] of the assembly register and wrap 3 -> 0.
REQ-022 LEN, 4th byte: N == 0 -> DONE (or CKSUM when the macro is defined); N > DEPTH -> ERR; otherwise -> DATA.
REQ-023 DATA, 4th byte: -> WRITE on the next edge.
REQ-024 In WRITE, o_mem_wr_en SHALL be 1 for exactly one cycle, with o_mem_wr_addr = word index (starting at 0) and o_mem_wr_data = the assembled word.
REQ-025 WRITE -> DATA while index + 1 < N, and the index SHALL then increment; otherwise -> DONE (or CKSUM when the macro is defined).
REQ-026 Minimum cost per word SHALL be 5 cycles: 4 accept cycles plus 1 write cycle.
REQ-027 o_mem_wr_en SHALL be 0 in every state other than WRITE, and o_mem_wr_addr/o_mem_wr_data SHALL hold their last values.
REQ-028 o_cpu_rst_n SHALL be 1 only in DONE; it is 0 in IDLE, LEN, DATA, WRITE, CKSUM and ERR.
REQ-029 o_done SHALL be 1 only in DONE; o_err SHALL be 1 only in ERR.
REQ-030 Idle gaps in i_byte_valid SHALL stall the FSM without losing state or reordering bytes.

Reset
REQ-031 Asserting i_sys_rst_n low SHALL immediately force state IDLE, counters 0 and the assembly register 0.
REQ-032 During reset: o_byte_ready=0, o_mem_wr_en=0, o_mem_wr_addr=0, o_mem_wr_data=0, o_cpu_rst_n=0, o_done=0, o_err=0.
REQ-033 Reset in the middle of a load SHALL abort it with no further writes, and the next load SHALL need a new i_load_start.

Configuration
REQ-034 Macro LOADER_CHECKSUM_EN, when defined, SHALL add the CKSUM state, which receives a trailing 32-bit word and compares it with the mod-2^32 sum of the N data words (the count word is excluded).
REQ-035 With LOADER_CHECKSUM_EN, a match -> DONE and a mismatch -> ERR; memory writes already issued are not undone.
REQ-036 Without LOADER_CHECKSUM_EN, the CKSUM state and the sum register SHALL be absent, and the last WRITE (or N == 0) SHALL go directly to DONE.

Verification
REQ-037 Reset, start, bytes 02 00 00 00, 13 00 00 00, 93 00 10 00 -> writes addr0=0x00000013 then addr1=0x00100093; o_done=1 and o_cpu_rst_n=1 on the cycle after the 2nd write.
REQ-038 N = 0 (bytes 00 00 00 00) -> no writes; DONE 1 cycle after the 4th byte (macro off).
REQ-039 N = DEPTH+1 -> o_err=1 and o_cpu_rst_n=0, no writes, o_byte_ready=0; a later i_load_start -> LEN.
REQ-040 i_byte_valid toggled 1/0 every cycle during REQ-037 -> same writes and data; o_byte_ready=0 during each WRITE cycle.
REQ-041 i_sys_rst_n low after 6 data bytes -> all outputs at reset values at once; no write is issued for the partial word.
REQ-042 Macro on, REQ-037 stream plus checksum bytes A6 00 10 00 -> DONE; with checksum 00 00 00 00 -> ERR after both writes.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: receives a word count and N little-endian words,
// writes them to instruction memory, then releases the core. Define LOADER_CHECKSUM_EN for a trailing checksum word.
module imem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst_n,
    input  logic                  i_load_start,
    input  logic                  i_byte_valid,
    input  logic [7:0]            i_byte_data,
    output logic                  o_byte_ready,
    output logic                  o_mem_wr_en,
    output logic [ADDR_WIDTH-1:0] o_mem_wr_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wr_data,
    output logic                  o_cpu_rst_n,
    output logic                  o_done,
    output logic                  o_err
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CKSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [1:0]              byte_cnt;
    logic [DATA_WIDTH-1:0]   asm_word;
    logic [DATA_WIDTH-1:0]   word_full;
    logic [31:0]             len_word;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    accept;
    logic                    last_byte;
    logic                    start_load;
    logic                    more_words;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]   sum;
`endif

    function automatic logic [DATA_WIDTH-1:0] insert_byte(
        input logic [DATA_WIDTH-1:0] w,
        input logic [1:0]            k,
        input logic [7:0]            b
    );
        logic [DATA_WIDTH-1:0] r;
        r = w;
        r[{k, 3'b000} +: 8] = b;
        return r;
    endfunction

    assign o_byte_ready = (state == S_LEN) || (state == S_DATA)
`ifdef LOADER_CHECKSUM_EN
                          || (state == S_CKSUM)
`endif
                          ;
    assign accept     = i_byte_valid && o_byte_ready;
    assign last_byte  = accept && (byte_cnt == 2'd3);
    assign word_full  = insert_byte(asm_word, byte_cnt, i_byte_data);
    assign start_load = i_load_start &&
                        ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    assign more_words = (32'(idx) + 32'd1) < len_word;

    assign o_mem_wr_addr = wr_addr;
    assign o_mem_wr_data = wr_data;

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        o_mem_wr_en = 1'b0;
        o_cpu_rst_n = 1'b0;
        o_done      = 1'b0;
        o_err       = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_load_start) state_nxt = S_LEN;
            end
            S_LEN: begin
                if (last_byte) begin
                    if (word_full == '0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_nxt = S_CKSUM;
`else
                        state_nxt = S_DONE;
`endif
                    end else if (32'(word_full) > DEPTH_W) begin
                        state_nxt = S_ERR;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (last_byte) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                o_mem_wr_en = 1'b1;
                if (more_words) begin
                    state_nxt = S_DATA;
                end else begin
`ifdef LOADER_CHECKSUM_EN
                    state_nxt = S_CKSUM;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CKSUM: begin
                if (last_byte) state_nxt = (word_full == sum) ? S_DONE : S_ERR;
            end
`endif
            S_DONE: begin
                o_done      = 1'b1;
                o_cpu_rst_n = 1'b1;
                if (i_load_start) state_nxt = S_LEN;
            end
            S_ERR: begin
                o_err = 1'b1;
                if (i_load_start) state_nxt = S_LEN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Write address/data are latched as the last byte of a word arrives, so they
    // stay valid through WRITE and hold afterwards.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            byte_cnt <= '0;
            asm_word <= '0;
            len_word <= '0;
            idx      <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum      <= '0;
`endif
        end else if (start_load) begin
            byte_cnt <= '0;
            asm_word <= '0;
            idx      <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum      <= '0;
`endif
        end else begin
            if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                asm_word <= word_full;
            end
            if ((state == S_LEN) && last_byte) begin
                len_word <= 32'(word_full);
            end
            if ((state == S_DATA) && last_byte) begin
                wr_addr <= idx;
                wr_data <= word_full;
            end
            if (state == S_WRITE) begin
`ifdef LOADER_CHECKSUM_EN
                sum <= sum + wr_data;
`endif
                if (more_words) idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized loads
// checked against a word-list model of the byte stream.
module tb_imem_loader;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 10;
    localparam int DEPTH      = 1024;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  load_start = 1'b0;
    logic                  byte_valid = 1'b0;
    logic [7:0]            byte_data = 8'h00;
    logic                  byte_ready;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic                  cpu_rst_n;
    logic                  done;
    logic                  err;

    int checks = 0;
    int failures = 0;

    logic [ADDR_WIDTH-1:0] got_addr[$];
    logic [DATA_WIDTH-1:0] got_data[$];
    logic [31:0]           exp_q[$];

    imem_loader #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .i_sys_clk(clk),
        .i_sys_rst_n(rst_n),
        .i_load_start(load_start),
        .i_byte_valid(byte_valid),
        .i_byte_data(byte_data),
        .o_byte_ready(byte_ready),
        .o_mem_wr_en(mem_wr_en),
        .o_mem_wr_addr(mem_wr_addr),
        .o_mem_wr_data(mem_wr_data),
        .o_cpu_rst_n(cpu_rst_n),
        .o_done(done),
        .o_err(err)
    );

    always #5 clk = ~clk;

    // Write monitor; a write cycle must never accept a byte.
    always @(negedge clk) begin
        if (mem_wr_en === 1'b1) begin
            got_addr.push_back(mem_wr_addr);
            got_data.push_back(mem_wr_data);
            checks++;
            if (byte_ready !== 1'b0) begin
                failures++;
                $display("FAIL ready_in_write: byte_ready=%b required 0", byte_ready);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        load_start = 1'b0;
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic pulse_start();
        got_addr.delete();
        got_data.delete();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Called and returns at a falling edge; valid is held until the byte is accepted.
    task automatic send_byte(input logic [7:0] b, input int gmin, input int gmax);
        int g;
        int n;
        g = $urandom_range(gmax, gmin);
        repeat (g) @(negedge clk);
        byte_valid = 1'b1;
        byte_data = b;
        n = 0;
        while (byte_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL byte_timeout: byte_ready=%b required 1 within 100 cycles", byte_ready);
        end else begin
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gmin, input int gmax);
        logic [31:0] t;
        t = w;
        for (int k = 0; k < 4; k++) begin
            send_byte(t[8*k +: 8], gmin, gmax);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({byte_ready, mem_wr_en, mem_wr_addr, mem_wr_data, cpu_rst_n, done, err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b wr_en=%b addr=%h data=%h cpu=%b done=%b err=%b required all 0",
                     byte_ready, mem_wr_en, mem_wr_addr, mem_wr_data, cpu_rst_n, done, err);
        end
        rst_n = 1'b1;
        byte_valid = 1'b1;
        byte_data = 8'h55;
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        checks++;
        if (byte_ready !== 1'b0 || cpu_rst_n !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_outputs: ready=%b cpu=%b done=%b required 0 0 0", byte_ready, cpu_rst_n, done);
        end
    endtask

    task automatic test_basic();
        pulse_start();
        checks++;
        if (byte_ready !== 1'b1) begin
            failures++;
            $display("FAIL len_ready: byte_ready=%b required 1", byte_ready);
        end
        send_word(32'd2, 0, 0);
        send_word(32'h0000_0013, 0, 0);
        send_word(32'h0010_0093, 0, 0);
        checks++;
        if (mem_wr_en !== 1'b1 || mem_wr_addr !== 10'd1 || mem_wr_data !== 32'h0010_0093 || done !== 1'b0) begin
            failures++;
            $display("FAIL basic_last_write: wr_en=%b addr=%0d data=%h done=%b required 1 1 00100093 0",
                     mem_wr_en, mem_wr_addr, mem_wr_data, done);
        end
`ifdef LOADER_CHECKSUM_EN
        send_word(32'h0010_00A6, 0, 0);
`else
        @(negedge clk);
`endif
        checks++;
        if (done !== 1'b1 || cpu_rst_n !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL basic_done: done=%b cpu=%b err=%b required 1 1 0", done, cpu_rst_n, err);
        end
        checks++;
        if (got_data.size() != 2 || got_addr[0] !== 10'd0 || got_data[0] !== 32'h13 ||
            got_addr[1] !== 10'd1 || got_data[1] !== 32'h0010_0093) begin
            failures++;
            $display("FAIL basic_writes: count=%0d required 2 with 0:00000013 1:00100093", got_data.size());
        end
        @(negedge clk);
        checks++;
        if (mem_wr_addr !== 10'd1 || mem_wr_data !== 32'h0010_0093 || mem_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL hold_write_bus: addr=%0d data=%h en=%b required 1 00100093 0",
                     mem_wr_addr, mem_wr_data, mem_wr_en);
        end
    endtask

    task automatic test_zero_len();
        pulse_start();
        send_word(32'd0, 0, 0);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'd0, 0, 0);
`endif
        checks++;
        if (done !== 1'b1 || cpu_rst_n !== 1'b1) begin
            failures++;
            $display("FAIL zero_len_done: done=%b cpu=%b required 1 1", done, cpu_rst_n);
        end
        checks++;
        if (got_data.size() != 0) begin
            failures++;
            $display("FAIL zero_len_writes: count=%0d required 0", got_data.size());
        end
    endtask

    task automatic test_overflow();
        pulse_start();
        send_word(32'(DEPTH + 1), 0, 0);
        checks++;
        if (err !== 1'b1 || cpu_rst_n !== 1'b0 || byte_ready !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL overflow_err: err=%b cpu=%b ready=%b done=%b required 1 0 0 0",
                     err, cpu_rst_n, byte_ready, done);
        end
        byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        checks++;
        if (got_data.size() != 0 || err !== 1'b1) begin
            failures++;
            $display("FAIL overflow_no_write: writes=%0d err=%b required 0 1", got_data.size(), err);
        end
        pulse_start();
        checks++;
        if (byte_ready !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL overflow_restart: ready=%b err=%b required 1 0", byte_ready, err);
        end
        do_reset();
    endtask

    task automatic test_valid_toggle();
        int n;
        pulse_start();
        send_word(32'd2, 1, 1);
        send_word(32'h0000_0013, 1, 1);
        send_word(32'h0010_0093, 1, 1);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'h0010_00A6, 1, 1);
`endif
        n = 0;
        while (done !== 1'b1 && err !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL toggle_done: done=%b err=%b required 1 0", done, err);
        end
        checks++;
        if (got_data.size() != 2 || got_addr[0] !== 10'd0 || got_data[0] !== 32'h13 ||
            got_addr[1] !== 10'd1 || got_data[1] !== 32'h0010_0093) begin
            failures++;
            $display("FAIL toggle_writes: count=%0d required 2 with 0:00000013 1:00100093", got_data.size());
        end
    endtask

    task automatic test_reset_mid_load();
        pulse_start();
        send_word(32'd2, 0, 0);
        send_word(32'hCAFE_0013, 0, 0);
        send_byte(8'h93, 0, 0);
        send_byte(8'h00, 0, 0);
        byte_valid = 1'b1;
        byte_data = 8'h10;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({byte_ready, mem_wr_en, mem_wr_addr, mem_wr_data, cpu_rst_n, done, err} !== '0) begin
            failures++;
            $display("FAIL midload_reset: ready=%b wr_en=%b addr=%h data=%h cpu=%b done=%b err=%b required all 0",
                     byte_ready, mem_wr_en, mem_wr_addr, mem_wr_data, cpu_rst_n, done, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        byte_valid = 1'b0;
        checks++;
        if (got_data.size() != 1 || got_data[0] !== 32'hCAFE_0013 || byte_ready !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midload_no_partial: writes=%0d ready=%b done=%b required 1 0 0",
                     got_data.size(), byte_ready, done);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum_bad();
        pulse_start();
        send_word(32'd2, 0, 0);
        send_word(32'h0000_0013, 0, 0);
        send_word(32'h0010_0093, 0, 0);
        send_word(32'h0000_0000, 0, 0);
        checks++;
        if (err !== 1'b1 || done !== 1'b0 || cpu_rst_n !== 1'b0) begin
            failures++;
            $display("FAIL cksum_bad: err=%b done=%b cpu=%b required 1 0 0", err, done, cpu_rst_n);
        end
        checks++;
        if (got_data.size() != 2) begin
            failures++;
            $display("FAIL cksum_bad_writes: count=%0d required 2", got_data.size());
        end
    endtask
`endif

    task automatic test_random();
        int          n;
        int          cyc;
        bit          exp_err;
        bit          cks_good;
        logic [31:0] s;
        logic [31:0] w;
        for (int it = 0; it < 10; it++) begin
            n = ($urandom_range(7, 0) == 0) ? DEPTH + 1 + int'($urandom_range(50, 0)) : int'($urandom_range(6, 0));
            cks_good = ($urandom_range(3, 0) != 0);
            exp_q.delete();
            s = 32'd0;
            if (n <= DEPTH) begin
                for (int i = 0; i < n; i++) begin
                    w = $urandom;
                    exp_q.push_back(w);
                    s = s + w;
                end
            end
            exp_err = (n > DEPTH);
`ifdef LOADER_CHECKSUM_EN
            exp_err = exp_err || !cks_good;
`endif
            pulse_start();
            send_word(32'(n), 0, 2);
            if (n <= DEPTH) begin
                foreach (exp_q[i]) send_word(exp_q[i], 0, 2);
`ifdef LOADER_CHECKSUM_EN
                send_word(cks_good ? s : s ^ (32'd1 << $urandom_range(31, 0)), 0, 2);
`endif
            end
            cyc = 0;
            while (done !== 1'b1 && err !== 1'b1 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            checks++;
            if (done !== !exp_err || err !== exp_err || cpu_rst_n !== !exp_err) begin
                failures++;
                $display("FAIL rand_outcome[%0d]: n=%0d done=%b err=%b cpu=%b required err=%b",
                         it, n, done, err, cpu_rst_n, exp_err);
            end
            checks++;
            if (got_data.size() != exp_q.size()) begin
                failures++;
                $display("FAIL rand_count[%0d]: writes=%0d required %0d", it, got_data.size(), exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    checks++;
                    if (got_addr[i] !== ADDR_WIDTH'(i) || got_data[i] !== exp_q[i]) begin
                        failures++;
                        $display("FAIL rand_write[%0d][%0d]: addr=%0d data=%h required addr=%0d data=%h",
                                 it, i, got_addr[i], got_data[i], i, exp_q[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_zero_len();
        test_overflow();
        test_valid_toggle();
        test_reset_mid_load();
`ifdef LOADER_CHECKSUM_EN
        test_checksum_bad();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
